// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path: FSM encoding and payload layout.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_FLUSH = 2'd2,
    ACK        = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int unsigned         k;
  logic [IDX_W-1:0]    k_idx;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      k_idx = IDX_W'(k);
      if (!valid && req[k_idx]) begin
        grant[k_idx] = 1'b1;
        idx          = k_idx;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: round-robin grant,
// data_ready pulse, wait for flush (or time out), then one-cycle ack to the winner.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             i_req,
  input  logic [N_REQ*REG_ADDR_W-1:0]  i_req_rd,
  input  logic [N_REQ*XLEN-1:0]        i_req_data,
  output logic [N_REQ-1:0]             o_ack,
  output logic [REG_ADDR_W-1:0]        o_rf_rd,
  output logic [XLEN-1:0]              o_rf_wdata,
  output logic                         o_rf_data_ready,
  input  logic                         i_rf_flush,
  output logic                         o_busy,
  output logic                         o_pending_valid,
  output logic [REG_ADDR_W-1:0]        o_pending_rd,
  output logic                         o_timeout_err,
  output logic [CNT_W-1:0]             o_write_count
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

  wb_state_e              state, state_next;
  logic [N_REQ-1:0]       grant, hold_grant;
  logic [IDX_W-1:0]       grant_idx, hold_idx, ptr;
  logic                   grant_valid;
  wb_req_t                grant_req;
  logic [REG_ADDR_W-1:0]  hold_rd;
  logic [TMR_W-1:0]       timer;

  logic                   flush_hit_c, timeout_c, load_port_c;
  logic                   data_ready_c, busy_c, pending_valid_c;
  logic [REG_ADDR_W-1:0]  sel_rd_c, pending_rd_c;
  logic [N_REQ-1:0]       ack_c;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (i_req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .valid (grant_valid)
  );

  assign grant_req.rd   = i_req_rd[32'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign grant_req.data = i_req_data[32'(grant_idx)*XLEN +: XLEN];

  assign flush_hit_c = (state == WAIT_FLUSH) && i_rf_flush;
  assign timeout_c   = (state == WAIT_FLUSH) && !i_rf_flush && (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // x0 writes skip the port entirely and go straight to ACK.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (grant_valid) state_next = (grant_req.rd == '0) ? ACK : ISSUE;
      ISSUE:      state_next = WAIT_FLUSH;
      WAIT_FLUSH: if (flush_hit_c || timeout_c) state_next = ACK;
      ACK:        state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed off the state being entered.
  always_comb begin
    sel_rd_c        = (state == IDLE) ? grant_req.rd : hold_rd;
    ack_c           = '0;
    data_ready_c    = (state_next == ISSUE);
    busy_c          = (state_next != IDLE);
    pending_valid_c = busy_c && (sel_rd_c != '0);
    pending_rd_c    = pending_valid_c ? sel_rd_c : '0;
    load_port_c     = (state == IDLE) && grant_valid && (grant_req.rd != '0);
    if (state_next == ACK) ack_c = (state == IDLE) ? grant : hold_grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_grant <= '0;
      hold_idx   <= '0;
      hold_rd    <= '0;
      ptr        <= '0;
      timer      <= '0;
    end else begin
      if (state == IDLE && grant_valid) begin
        hold_grant <= grant;
        hold_idx   <= grant_idx;
        hold_rd    <= grant_req.rd;
      end
      if (state == ACK)
        ptr <= (hold_idx == IDX_W'(N_REQ - 1)) ? '0 : hold_idx + IDX_W'(1);
      timer <= (state == WAIT_FLUSH) ? timer + TMR_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_ack           <= '0;
      o_rf_rd         <= '0;
      o_rf_wdata      <= '0;
      o_rf_data_ready <= 1'b0;
      o_busy          <= 1'b0;
      o_pending_valid <= 1'b0;
      o_pending_rd    <= '0;
      o_timeout_err   <= 1'b0;
      o_write_count   <= '0;
    end else begin
      o_ack           <= ack_c;
      o_rf_data_ready <= data_ready_c;
      o_busy          <= busy_c;
      o_pending_valid <= pending_valid_c;
      o_pending_rd    <= pending_rd_c;
      o_timeout_err   <= o_timeout_err | timeout_c;
      if (flush_hit_c) o_write_count <= o_write_count + CNT_W'(1);
      if (load_port_c) begin
        o_rf_rd    <= grant_req.rd;
        o_rf_wdata <= grant_req.data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (round-robin order, register contents, counters).
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int TO = 15;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*5-1:0]  req_rd;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    ack;
  logic [4:0]      rf_rd;
  logic [31:0]     rf_wdata;
  logic            rf_dr;
  logic            rf_flush;
  logic            busy, pv, terr;
  logic [4:0]      prd;
  logic [CW-1:0]   wcnt;
  logic            model_flush, stray_flush;

  assign rf_flush = model_flush | stray_flush;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N_REQ(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (req),
    .i_req_rd        (req_rd),
    .i_req_data      (req_data),
    .o_ack           (ack),
    .o_rf_rd         (rf_rd),
    .o_rf_wdata      (rf_wdata),
    .o_rf_data_ready (rf_dr),
    .i_rf_flush      (rf_flush),
    .o_busy          (busy),
    .o_pending_valid (pv),
    .o_pending_rd    (prd),
    .o_timeout_err   (terr),
    .o_write_count   (wcnt)
  );

  int          checks = 0;
  int          errors = 0;
  bit          act[N];
  logic [4:0]  rd_a[N];
  logic [31:0] dat_a[N];
  logic [31:0] rf_mem[32];
  logic [31:0] rf_exp[32];
  int          ptr_m, cnt_m;
  bit          err_m;
  bit          flush_en, rand_dly, corrupt;
  int          flush_cnt, dr_cnt;
  bit          dr_prev, inflight, pv_seen;
  logic [4:0]  cap_rd;
  logic [31:0] cap_dat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k]            = act[k];
      req_rd[k*5 +: 5]  = rd_a[k];
      req_data[k*32 +: 32] = dat_a[k];
    end
  endtask

  function automatic int rr_pick();
    for (int i = 0; i < N; i++) begin
      if (act[(ptr_m + i) % N]) return (ptr_m + i) % N;
    end
    return 0;
  endfunction

  // One cycle: register-file model (flush after a delay), then protocol monitors.
  task automatic tick();
    @(negedge clk);
    model_flush = 1'b0;
    if (flush_cnt > 0) begin
      flush_cnt--;
      if (flush_cnt == 0) begin
        model_flush = 1'b1;
        rf_mem[rf_rd] = rf_wdata;
      end
    end
    if (rf_dr) begin
      check("dr_low_before", 64'(dr_prev), 64'd0);
      dr_cnt++;
      cap_rd   = rf_rd;
      cap_dat  = rf_wdata;
      inflight = 1'b1;
      if (corrupt) req_data = ~req_data;
      if (flush_en) flush_cnt = rand_dly ? int'($urandom_range(1, 10)) : 5;
    end else if (inflight) begin
      check("rd_stable", 64'(rf_rd), 64'(cap_rd));
      check("wdata_stable", 64'(rf_wdata), 64'(cap_dat));
      check("busy_in_flight", 64'(busy), 64'd1);
    end
    if (pv) begin
      pv_seen = 1'b1;
      check("pending_rd", 64'(prd), 64'(cap_rd));
    end else begin
      check("pending_rd_zero", 64'(prd), 64'd0);
    end
    if (ack != '0) begin
      check("ack_onehot", 64'($onehot(ack)), 64'd1);
      inflight = 1'b0;
    end
    dr_prev = rf_dr;
  endtask

  task automatic transact(output int got, output int lat);
    int          exp;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
    exp   = rr_pick();
    e_rd  = rd_a[exp];
    e_dat = dat_a[exp];
    got = -1; lat = 0; dr_cnt = 0; pv_seen = 1'b0;
    while (got < 0 && lat < 200) begin
      tick();
      lat++;
      for (int k = N - 1; k >= 0; k--) if (ack[k]) got = k;
    end
    check("ack_seen", 64'(got >= 0), 64'd1);
    check("ack_idx", 64'(got), 64'(exp));
    if (e_rd != 5'd0) begin
      if (flush_en) begin
        cnt_m++;
        rf_exp[e_rd] = e_dat;
      end else begin
        err_m = 1'b1;
      end
    end
    check("write_count", 64'(wcnt), 64'(CW'(cnt_m)));
    check("timeout_err", 64'(terr), 64'(err_m));
    check("dr_pulses", 64'(dr_cnt), 64'(e_rd != 5'd0));
    check("pending_seen", 64'(pv_seen), 64'(e_rd != 5'd0));
    if (e_rd != 5'd0) check("rf_content", 64'(rf_mem[e_rd]), 64'(rf_exp[e_rd]));
    ptr_m = (exp + 1) % N;
    if (got >= 0) act[got] = 1'b0;
    drive();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_dr"}, 64'(rf_dr), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pv"}, 64'(pv), 64'd0);
    check({tag, "_prd"}, 64'(prd), 64'd0);
    check({tag, "_terr"}, 64'(terr), 64'd0);
    check({tag, "_wcnt"}, 64'(wcnt), 64'd0);
    check({tag, "_rf_rd"}, 64'(rf_rd), 64'd0);
    check({tag, "_rf_wdata"}, 64'(rf_wdata), 64'd0);
  endtask

  task automatic reset_dut(input string tag);
    rst = 1'b0;
    #1;
    check_zero(tag);
    @(negedge clk);
    check({tag, "_no_ack"}, 64'(ack), 64'd0);
    rst = 1'b1;
    ptr_m = 0; cnt_m = 0; err_m = 1'b0;
    flush_cnt = 0; model_flush = 1'b0;
    inflight = 1'b0; dr_prev = 1'b0;
  endtask

  initial begin
    int got, lat, n;
    rst = 1'b1;
    stray_flush = 1'b0; model_flush = 1'b0;
    flush_en = 1'b1; rand_dly = 1'b0; corrupt = 1'b0;
    flush_cnt = 0; dr_cnt = 0;
    for (int k = 0; k < N; k++) begin act[k] = 1'b0; rd_a[k] = '0; dat_a[k] = '0; end
    for (int r = 0; r < 32; r++) begin rf_mem[r] = '0; rf_exp[r] = '0; end
    drive();
    #2;
    reset_dut("reset");

    // Single nominal write, payload scrambled after grant.
    act[0] = 1'b1; rd_a[0] = 5'd5; dat_a[0] = 32'h1234;
    drive();
    corrupt = 1'b1;
    transact(got, lat);
    corrupt = 1'b0;
    check("single_latency", 64'(lat), 64'd7);
    check("single_reg5", 64'(rf_mem[5]), 64'h1234);
    check("single_count", 64'(wcnt), 64'd1);

    // x0 write requested during the previous ACK cycle.
    act[1] = 1'b1; rd_a[1] = 5'd0; dat_a[1] = 32'hFFFF;
    drive();
    transact(got, lat);
    check("x0_idx", 64'(got), 64'd1);
    check("x0_latency", 64'(lat), 64'd2);
    check("x0_count", 64'(wcnt), 64'd1);

    // Flush while idle must be ignored.
    tick();
    stray_flush = 1'b1;
    tick();
    stray_flush = 1'b0;
    tick();
    check("stray_flush_count", 64'(wcnt), 64'(CW'(cnt_m)));
    check("stray_flush_busy", 64'(busy), 64'd0);

    // Contention from a fresh pointer; requester 0 re-requests on its ack.
    reset_dut("reset2");
    for (int k = 0; k < N; k++) begin
      act[k] = 1'b1; rd_a[k] = 5'(k + 1); dat_a[k] = $urandom;
    end
    drive();
    transact(got, lat);
    check("cont_first", 64'(got), 64'd0);
    act[0] = 1'b1; rd_a[0] = 5'd4; dat_a[0] = $urandom;
    drive();
    transact(got, lat);
    check("cont_second", 64'(got), 64'd1);
    transact(got, lat);
    check("cont_third", 64'(got), 64'd2);
    check("cont_count3", 64'(wcnt), 64'd3);
    transact(got, lat);
    check("cont_fourth", 64'(got), 64'd0);

    // Fairness: park the pointer on 0, then hammer requester 0 while 2 waits.
    act[2] = 1'b1; rd_a[2] = 5'd10; dat_a[2] = $urandom;
    drive();
    transact(got, lat);
    act[0] = 1'b1; rd_a[0] = 5'd11; dat_a[0] = $urandom;
    act[2] = 1'b1; rd_a[2] = 5'd12; dat_a[2] = $urandom;
    drive();
    n = 0;
    got = -1;
    while (got != 2 && n < 3) begin
      transact(got, lat);
      n++;
      if (got == 0) begin
        act[0] = 1'b1; dat_a[0] = $urandom;
        drive();
      end
    end
    check("fair_served_by_2", 64'(n <= 2 && got == 2), 64'd1);
    act[0] = 1'b0;
    drive();
    tick(); tick();

    // Reset in the middle of WAIT_FLUSH, then the same requester retries.
    act[1] = 1'b1; rd_a[1] = 5'd9; dat_a[1] = 32'hCAFE_0009;
    drive();
    for (int c = 0; c < 4; c++) tick();
    check("mid_busy_before_reset", 64'(busy), 64'd1);
    reset_dut("midreset");
    transact(got, lat);
    check("midreset_retry_idx", 64'(got), 64'd1);
    check("midreset_retry_reg9", 64'(rf_mem[9]), 64'hCAFE_0009);

    // Timeout with the flush model silenced.
    tick(); tick();
    flush_en = 1'b0;
    act[2] = 1'b1; rd_a[2] = 5'd7; dat_a[2] = 32'hDEAD_0007;
    drive();
    transact(got, lat);
    check("timeout_latency", 64'(lat), 64'(TO + 2));
    check("timeout_err_set", 64'(terr), 64'd1);
    flush_en = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    check("timeout_err_sticky", 64'(terr), 64'd1);

    // Randomized traffic with random flush delays.
    rand_dly = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++) begin
        if (!act[k] && $urandom_range(0, 1) == 1) begin
          act[k]   = 1'b1;
          rd_a[k]  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          dat_a[k] = $urandom;
        end
      end
      if (!act[0] && !act[1] && !act[2]) begin
        n = int'($urandom_range(0, N - 1));
        act[n] = 1'b1; rd_a[n] = 5'($urandom_range(1, 31)); dat_a[n] = $urandom;
      end
      drive();
      transact(got, lat);
    end
    check("final_err_sticky", 64'(terr), 64'(err_m));
    check("final_count", 64'(wcnt), 64'(CW'(cnt_m)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
